// File: rtl/i2c_master_timer_pkg.sv
// I2C master timer shared types.
// Commands, SDA source select, FSM state codes.
package i2c_master_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_START = 2'd1,
        CMD_BYTE  = 2'd2,
        CMD_STOP  = 2'd3
    } i2c_cmd_t;

    typedef enum logic [1:0] {
        SDA_DATA = 2'd0,
        SDA_LOW  = 2'd1,
        SDA_HIGH = 2'd2
    } sda_sel_t;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE  = 4'd0;
    localparam state_t S_RS_A  = 4'd1;
    localparam state_t S_ST_A  = 4'd2;
    localparam state_t S_ST_B  = 4'd3;
    localparam state_t S_ST_C  = 4'd4;
    localparam state_t S_HOLD  = 4'd5;
    localparam state_t S_BIT_L = 4'd6;
    localparam state_t S_BIT_H = 4'd7;
    localparam state_t S_SP_A  = 4'd8;
    localparam state_t S_SP_B  = 4'd9;
    localparam state_t S_SP_C  = 4'd10;

    localparam logic [3:0] ACK_BIT       = 4'd8;
    localparam logic [3:0] LAST_DATA_BIT = 4'd7;

    function automatic logic scl_pull(
        input state_t s
    );
        logic r;
        r = 1'b0;
        case (s)
            S_RS_A,
            S_ST_C,
            S_HOLD,
            S_BIT_L,
            S_SP_A:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic sda_sel_t sda_of(
        input state_t s
    );
        sda_sel_t r;
        r = SDA_HIGH;
        case (s)
            S_ST_B,
            S_ST_C,
            S_HOLD,
            S_SP_A,
            S_SP_B:  r = SDA_LOW;
            S_BIT_L,
            S_BIT_H: r = SDA_DATA;
            default: r = SDA_HIGH;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/i2c_master_timer_if.sv
// Command handshake and bus-side signals
// between the master control FSM and the timer.
interface i2c_master_timer_if;
    import i2c_master_pkg::*;

    i2c_cmd_t   cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       scl_in;
    logic       scl_oe;
    sda_sel_t   sda_sel;
    logic       shift_strobe;
    logic       sample_strobe;
    logic [3:0] bit_cnt;
    logic       byte_received;
    logic       ack_prep;
    logic       ack_check;
    logic       ack_done;
    logic       stop_done;
    logic       cmd_error;
    logic       busy;

    modport master (
        output cmd,
        output cmd_valid,
        output scl_in,
        input  cmd_ready,
        input  scl_oe,
        input  sda_sel,
        input  shift_strobe,
        input  sample_strobe,
        input  bit_cnt,
        input  byte_received,
        input  ack_prep,
        input  ack_check,
        input  ack_done,
        input  stop_done,
        input  cmd_error,
        input  busy
    );

    modport slave (
        input  cmd,
        input  cmd_valid,
        input  scl_in,
        output cmd_ready,
        output scl_oe,
        output sda_sel,
        output shift_strobe,
        output sample_strobe,
        output bit_cnt,
        output byte_received,
        output ack_prep,
        output ack_check,
        output ack_done,
        output stop_done,
        output cmd_error,
        output busy
    );

endinterface

// File: rtl/i2c_master_timer_quarter_cnt.sv
// Quarter-period counter with clear and
// clock-stretch hold; qtr marks the second quarter.
module i2c_quarter_cnt #(
    parameter  int QUARTER = 63,
    localparam int CNT_W   = $clog2(QUARTER)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tick,
    output logic qtr
);

    localparam logic [CNT_W-1:0] LAST =
        CNT_W'(QUARTER - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = !hold && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            qtr <= 1'b0;
        end else if (hold) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
            qtr <= ~qtr;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_master_timer.sv
// I2C master SCL generator and bit-phase sequencer:
// START / repeated START / byte / STOP on command.
module i2c_master_timer #(
    parameter int QUARTER = 63
) (
    input  logic              clk,
    input  logic              rst,
    i2c_master_timer_if.slave bus
);
    import i2c_master_pkg::*;

    state_t     state;
    state_t     nxt;
    logic       tick;
    logic       qtr;
    logic       clr;
    logic       hold;
    logic       accept;
    logic       last_q;
    logic       shift_n;
    logic       samp_n;
    logic       scl_n;
    sda_sel_t   sda_n;
    logic [3:0] bit_n;

    assign bus.cmd_ready = (state == S_IDLE) ||
                           (state == S_HOLD);
    assign bus.busy      = (state != S_IDLE);

    assign accept = bus.cmd_valid && bus.cmd_ready;
    assign last_q = tick && qtr;
    assign clr    = (nxt != state);

    // SCL released but still low: a slave is stretching
    assign hold = bus.busy && !bus.scl_oe &&
                  !bus.scl_in;

    i2c_quarter_cnt #(
        .QUARTER(QUARTER)
    ) u_qcnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .hold(hold),
        .tick(tick),
        .qtr (qtr)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept && bus.cmd == CMD_START)
                    nxt = S_ST_A;
            end
            S_HOLD: begin
                if (accept) begin
                    case (bus.cmd)
                        CMD_START: nxt = S_RS_A;
                        CMD_BYTE:  nxt = S_BIT_L;
                        CMD_STOP:  nxt = S_SP_A;
                        default:   nxt = S_HOLD;
                    endcase
                end
            end
            S_RS_A:  if (tick)   nxt = S_ST_A;
            S_ST_A:  if (tick)   nxt = S_ST_B;
            S_ST_B:  if (last_q) nxt = S_ST_C;
            S_ST_C:  if (tick)   nxt = S_HOLD;
            S_BIT_L: if (last_q) nxt = S_BIT_H;
            S_BIT_H: begin
                if (last_q)
                    nxt = (bus.bit_cnt == ACK_BIT) ?
                          S_HOLD : S_BIT_L;
            end
            S_SP_A:  if (tick)   nxt = S_SP_B;
            S_SP_B:  if (last_q) nxt = S_SP_C;
            S_SP_C:  if (last_q) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bit_n = bus.bit_cnt;
        if (state == S_BIT_H && nxt == S_BIT_L)
            bit_n = bus.bit_cnt + 4'd1;
        else if (nxt != S_BIT_L && nxt != S_BIT_H)
            bit_n = 4'd0;
    end

    assign shift_n = (nxt == S_BIT_L) &&
                     (state != S_BIT_L);
    assign samp_n  = (state == S_BIT_H) &&
                     tick && !qtr;
    assign scl_n   = scl_pull(nxt);
    assign sda_n   = sda_of(nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            bus.scl_oe        <= 1'b0;
            bus.sda_sel       <= SDA_HIGH;
            bus.bit_cnt       <= 4'd0;
            bus.shift_strobe  <= 1'b0;
            bus.sample_strobe <= 1'b0;
            bus.byte_received <= 1'b0;
            bus.ack_prep      <= 1'b0;
            bus.ack_check     <= 1'b0;
            bus.ack_done      <= 1'b0;
            bus.stop_done     <= 1'b0;
            bus.cmd_error     <= 1'b0;
        end else begin
            state      <= nxt;
            bus.scl_oe <= scl_n;
            // ACK -> HOLD: pull SCL first, move SDA a cycle later
            if (scl_n != bus.scl_oe &&
                sda_n != bus.sda_sel)
                bus.sda_sel <= bus.sda_sel;
            else
                bus.sda_sel <= sda_n;
            bus.bit_cnt       <= bit_n;
            bus.shift_strobe  <= shift_n;
            bus.ack_prep      <= shift_n &&
                                 (bit_n == ACK_BIT);
            bus.sample_strobe <= samp_n;
            bus.byte_received <= samp_n &&
                (bus.bit_cnt == LAST_DATA_BIT);
            bus.ack_check     <= samp_n &&
                (bus.bit_cnt == ACK_BIT);
            bus.ack_done      <= (state == S_BIT_H) &&
                                 (nxt == S_HOLD);
            bus.stop_done     <= (state == S_SP_C) &&
                                 (nxt == S_IDLE);
            bus.cmd_error     <= (state == S_IDLE) &&
                bus.cmd_valid &&
                (bus.cmd == CMD_BYTE ||
                 bus.cmd == CMD_STOP);
        end
    end

endmodule

// File: doc/i2c_master_timer.md
Name: i2c_master_timer

Overview:
- Master-side SCL generator and bit-phase sequencer for the I2C block. It is the initiator counterpart of the slave timer.
- Drives SCL and selects the SDA source, and issues START, repeated START, byte and STOP sequences on command.
- Emits per-bit shift/sample strobes plus byte and ACK markers to the master shift register and control FSM.
- Supports clock stretching by slaves.

Parameters:
- QUARTER, 63, clk cycles per quarter SCL period (SCL = clk/(4*QUARTER); 397 kHz at 100 MHz); legal range 2..65535.
- CNT_W, $clog2(QUARTER), width of quarter counter (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cmd  in  2  command code (i2c_cmd_t)
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready
- scl_in  in  1  synchronized SCL bus level (synchronizer upstream)
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_sel  out  2  SDA source (sda_sel_t): SDA_DATA, SDA_LOW, SDA_HIGH(release)
- shift_strobe  out  1  pulse: present next bit on SDA (SCL low)
- sample_strobe  out  1  pulse: sample SDA (SCL high midpoint)
- bit_cnt  out  4  current bit index 0..8 (8 = ACK bit)
- byte_received  out  1  pulse with sample_strobe of bit 7
- ack_prep  out  1  pulse with shift_strobe of bit 8
- ack_check  out  1  pulse with sample_strobe of bit 8
- ack_done  out  1  pulse when SCL pulled low after bit 8
- stop_done  out  1  pulse on return to IDLE after STOP
- cmd_error  out  1  pulse on illegal command
- busy  out  1  not IDLE

Behaviour:
- Reset values: state IDLE, scl_oe=0, sda_sel=SDA_HIGH, all pulses 0, bit_cnt=0, counter 0, busy=0.
- A reset asserted mid-operation returns to IDLE on the next edge and releases both lines; there is no graceful STOP.
- Quarter counter:
  - Counts 0..QUARTER-1; "tick" = counter==QUARTER-1. It clears on every state change.
  - In any phase with scl_oe=0 and SCL expected high, the counter holds at 0 while scl_in==0. This is clock stretching, and it has no timeout.
- cmd_ready=1 only in IDLE and HOLD. An accepted command changes state on the next edge (1-cycle latency).
- Commands:
  - CMD_START in IDLE starts a START sequence.
  - CMD_START in HOLD starts a repeated START.
  - CMD_BYTE in HOLD starts a byte.
  - CMD_STOP in HOLD starts a STOP.
  - CMD_BYTE or CMD_STOP in IDLE: ignored, cmd_error pulses next cycle.
  - CMD_NOP: ignored.
- States (durations in quarters; each "stretch" phase begins counting only once scl_in==1):
  - IDLE: scl_oe=0, SDA_HIGH.
  - RS_A (repeated START only): scl_oe=1, SDA_HIGH, 1 quarter -> ST_A.
  - ST_A: scl_oe=0, SDA_HIGH, 1 quarter, stretch -> ST_B.
  - ST_B: scl_oe=0, SDA_LOW, 2 quarters -> ST_C.
  - ST_C: scl_oe=1, SDA_LOW, 1 quarter -> HOLD.
  - HOLD: scl_oe=1, SDA_LOW, waits for a command.
  - BIT_L: scl_oe=1, SDA_DATA, 2 quarters.
    - On entry: shift_strobe; ack_prep also fires if bit_cnt==8.
    - -> BIT_H.
  - BIT_H: scl_oe=0, SDA_DATA, 2 quarters, stretch.
    - At tick of first quarter: sample_strobe; byte_received also fires if bit_cnt==7, ack_check if bit_cnt==8.
    - At end: if bit_cnt==8, go to HOLD with ack_done, bit_cnt=0.
    - Otherwise bit_cnt++ and go to BIT_L.
  - SP_A: scl_oe=1, SDA_LOW, 1 quarter -> SP_B.
  - SP_B: scl_oe=0, SDA_LOW, 2 quarters, stretch -> SP_C.
  - SP_C: scl_oe=0, SDA_HIGH, 2 quarters (bus free) -> IDLE, with stop_done.
- Line transitions:
  - SDA changes only while scl_oe=1, except the START/STOP edges in ST_B and SP_C.
  - sda_sel and scl_oe are registered outputs and never change in the same cycle.
- bit_cnt is valid from BIT_L entry through BIT_H. It holds 0 in all other states.

Decomposition:
- Package i2c_master_pkg: i2c_cmd_t (CMD_NOP=0, CMD_START=1, CMD_BYTE=2, CMD_STOP=3), sda_sel_t, state enum, bit constants ACK_BIT=8 and LAST_DATA_BIT=7.
- One sub-module i2c_quarter_cnt: counter with clear, stretch-hold and tick output.
- FSM and strobe logic stay in the top module.

Test Plan (QUARTER=4, scl_in tied to ~scl_oe unless noted):
- Reset 3 cycles then release -> scl_oe=0, sda_sel=SDA_HIGH, cmd_ready=1, busy=0.
- CMD_START in IDLE:
  - SDA_HIGH for 4 cycles with SCL released.
  - SDA_LOW for 8 cycles with SCL still released.
  - scl_oe=1 for 4 cycles.
  - HOLD entered 16 cycles after acceptance, cmd_ready=1.
- CMD_BYTE in HOLD:
  - Exactly 9 shift_strobe and 9 sample_strobe pulses, SCL period 16 cycles.
  - sample_strobe 4 cycles after each SCL release.
  - byte_received coincides with sample 7; ack_prep/ack_check on bit 8.
  - ack_done 144 cycles after acceptance.
- Clock stretch: during bit 3 BIT_H, hold scl_in=0 for 10 cycles after release -> sample_strobe delayed 10 cycles, ack_done at 154 cycles.
- CMD_START in HOLD (repeated START) then CMD_STOP:
  - Repeated START: RS_A 4 cycles then a normal START sequence.
  - STOP: SDA rises while SCL released, stop_done 20 cycles after STOP acceptance, then IDLE.
- CMD_BYTE in IDLE -> cmd_error 1 cycle, state stays IDLE. Assert rst mid-byte -> next cycle scl_oe=0, sda_sel=SDA_HIGH, bit_cnt=0.
